pulse_train_gen: RTL and testbench
==================================

# pulse_train_gen

Generates a programmable train of rectangular pulses on a single-bit line: high for a set number of clock cycles, low for a set number, repeated a set number of times. It is the transmit-side counterpart to the edge-detection logic: it produces the rising/falling edges that downstream edge detectors consume. It emits one-cycle strobes that mark each edge it creates, plus a start/busy/done handshake for the controlling FSM.

## Interface
- CNT_W, 8: width of high_cycles / low_cycles and the phase counter
- NUM_W, 8: width of num_pulses and the pulse counter

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request a train; sampled only when busy=0
- abort  in  1  terminate an active train
- high_cycles  in  CNT_W  high-phase length, sampled with start
- low_cycles  in  CNT_W  low-phase length, sampled with start
- num_pulses  in  NUM_W  pulse count, sampled with start
- signal_out  out  1  generated waveform (registered)
- rise_strb  out  1  high in the first cycle signal_out is 1 after a 0
- fall_strb  out  1  high in the first cycle signal_out is 0 after a 1
- busy  out  1  train in progress
- done  out  1  one-cycle pulse on normal completion

## Operation
- Reset: signal_out, rise_strb, fall_strb, busy and done are 0. State is IDLE and all counters are 0.
- States: IDLE, HIGH, LOW.
- IDLE + start (abort=0), num_pulses≠0:
  - Latch all three inputs.
  - Go to HIGH: signal_out=1, rise_strb=1, busy=1.
  - Phase counter = H−1, pulse counter = N.
- Zero lengths: high_cycles=0 is treated as 1; low_cycles=0 is treated as 1.
- HIGH: decrement the phase counter each cycle. When it reaches 0, go to LOW: signal_out=0, fall_strb=1, counter = L−1, pulse counter decremented.
- LOW: decrement the counter each cycle. When it reaches 0:
  - If the pulse counter ≠ 0: go to HIGH (rise_strb=1).
  - Otherwise: go to IDLE with busy=0 and done=1 for one cycle.
- start while busy=1 is ignored. Input changes while busy do not affect the active train.
- start during the done cycle (busy=0) is accepted.
- abort while busy:
  - At the next edge go to IDLE: signal_out=0, busy=0, done=0.
  - fall_strb=1 only if signal_out was 1.
  - abort takes priority over any phase transition in the same cycle.
- abort while idle has no effect. abort with start in IDLE: abort wins and start is dropped.
- rise_strb and fall_strb are never both 1. Each is high for exactly one cycle per edge.
- Counters are unsigned and never wrap. The maximum train is 2^NUM_W−1 pulses of up to 2^CNT_W−1 cycles per phase.

## Timing
- Start latency: start sampled at edge k → signal_out=1, rise_strb=1, busy=1 in cycle k+1.
- Each pulse: exactly H' high cycles, then L' low cycles, where H' = max(H,1) and L' = max(L,1).
- busy is high for N·(H'+L') cycles. done is high in the cycle immediately after busy falls.
- Back-to-back: a start accepted in the done cycle produces a low gap of L'+1 cycles between trains.
- Abort latency: abort sampled at edge k → signal_out=0 and busy=0 in cycle k+1.
- Reset asserted mid-train: all outputs go to 0 immediately, asynchronously. Operation resumes in IDLE after release.

## Configuration
- PULSE_TRAIN_CONT_EN defined: num_pulses=0 selects continuous mode.
  - The pulse counter is not decremented and the train repeats until abort.
  - done is never asserted in this mode.
- PULSE_TRAIN_CONT_EN undefined: start with num_pulses=0 emits no pulse.
  - State stays IDLE and busy stays 0.
  - done=1 for one cycle at k+1.

## Test plan
- H=2, L=3, N=2, start at edge 0: signal_out pattern from cycle 1 is 1,1,0,0,0,1,1,0,0,0; busy for cycles 1–10; done=1 in cycle 11 only; rise_strb in cycles 1 and 6; fall_strb in cycles 3 and 8.
- H=0, L=0, N=3: signal_out toggles 1,0,1,0,1,0 over 6 cycles; done in cycle 7.
- start pulsed mid-train (H=4, L=4, N=1), with inputs changed: waveform unchanged. start in the done cycle with H=1, L=1, N=1: signal_out rises one cycle after done, giving a low gap of 2.
- abort in the 2nd HIGH cycle (H=5, L=5, N=3): next cycle signal_out=0, fall_strb=1, busy=0, done never asserted. abort together with start in IDLE: no activity.
- num_pulses=0:
  - Without PULSE_TRAIN_CONT_EN: done=1 one cycle after start, busy and signal_out stay 0.
  - With PULSE_TRAIN_CONT_EN and H=1, L=2: ≥20 periods of 1,0,0 with no done; abort stops the train.
- rst_n asserted during a LOW phase of a train and held 3 cycles: all outputs 0 during reset; after release, a start with H=1, L=1, N=1 behaves as in the first scenario.

Source files
------------

// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - programmable high/low pulse train generator with edge strobes
// Optional continuous mode (num_pulses=0 repeats until abort): define PULSE_TRAIN_CONT_EN.
module pulse_train_gen #(
    parameter int CNT_W = 8,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] high_cycles,
    input  logic [CNT_W-1:0] low_cycles,
    input  logic [NUM_W-1:0] num_pulses,
    output logic             signal_out,
    output logic             rise_strb,
    output logic             fall_strb,
    output logic             busy,
    output logic             done
);

`ifdef PULSE_TRAIN_CONT_EN
    localparam bit CONT_EN = 1'b1;
`else
    localparam bit CONT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] high_lat;
    logic [CNT_W-1:0] low_lat;
    logic [NUM_W-1:0] pulse_cnt;
    logic             cont;

    // Phase reload value; a zero length behaves as a single cycle.
    function automatic logic [CNT_W-1:0] reload(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            high_lat   <= '0;
            low_lat    <= '0;
            pulse_cnt  <= '0;
            cont       <= 1'b0;
            signal_out <= 1'b0;
            rise_strb  <= 1'b0;
            fall_strb  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            rise_strb <= 1'b0;
            fall_strb <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (num_pulses != '0 || CONT_EN) begin
                            high_lat   <= high_cycles;
                            low_lat    <= low_cycles;
                            pulse_cnt  <= num_pulses;
                            cont       <= CONT_EN && (num_pulses == '0);
                            phase_cnt  <= reload(high_cycles);
                            state      <= HIGH;
                            signal_out <= 1'b1;
                            rise_strb  <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                HIGH, LOW: begin
                    // Abort outranks any phase transition due in the same cycle.
                    if (abort) begin
                        state      <= IDLE;
                        signal_out <= 1'b0;
                        fall_strb  <= signal_out;
                        busy       <= 1'b0;
                    end else if (phase_cnt != '0) begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end else if (state == HIGH) begin
                        state      <= LOW;
                        signal_out <= 1'b0;
                        fall_strb  <= 1'b1;
                        phase_cnt  <= reload(low_lat);
                        if (!cont) begin
                            pulse_cnt <= pulse_cnt - 1'b1;
                        end
                    end else if (cont || pulse_cnt != '0) begin
                        state      <= HIGH;
                        signal_out <= 1'b1;
                        rise_strb  <= 1'b1;
                        phase_cnt  <= reload(high_lat);
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    signal_out <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb/tb_pulse_train_gen.sv - randomized self-checking bench for pulse_train_gen
module tb_pulse_train_gen;

`ifdef PULSE_TRAIN_CONT_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] high_cycles;
    logic [7:0] low_cycles;
    logic [7:0] num_pulses;
    logic       signal_out;
    logic       rise_strb;
    logic       fall_strb;
    logic       busy;
    logic       done;

    int vectors     = 0;
    int miscompares = 0;

    pulse_train_gen #(.CNT_W(8), .NUM_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .high_cycles (high_cycles),
        .low_cycles  (low_cycles),
        .num_pulses  (num_pulses),
        .signal_out  (signal_out),
        .rise_strb   (rise_strb),
        .fall_strb   (fall_strb),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] obs();
        return {signal_out, rise_strb, fall_strb, busy, done};
    endfunction

    // Expected {signal_out, rise, fall, busy, done} in cycle t (t=1 is the cycle after start is taken).
    function automatic logic [4:0] model(input int h, input int l, input int n, input int t);
        int hp;
        int lp;
        int p;
        int ph;
        logic [4:0] r;
        hp = (h == 0) ? 1 : h;
        lp = (l == 0) ? 1 : l;
        p  = hp + lp;
        r  = 5'b0;
        if ((CONT && n == 0) || t <= n * p) begin
            ph = (t - 1) % p;
            r  = {ph < hp, ph == 0, ph == hp, 1'b1, 1'b0};
        end else if (t == n * p + 1) begin
            r = 5'b00001;
        end
        return r;
    endfunction

    function automatic int train_len(input int h, input int l, input int n);
        return n * (((h == 0) ? 1 : h) + ((l == 0) ? 1 : l)) + 1;
    endfunction

    task automatic start_train(input int h, input int l, input int n);
        high_cycles = 8'(h);
        low_cycles  = 8'(l);
        num_pulses  = 8'(n);
        start       = 1'b1;
    endtask

    task automatic check_train(input string name, input int h, input int l, input int n,
                               input int ncyc, input bit noise);
        logic [4:0] exp;
        for (int t = 1; t <= ncyc; t++) begin
            @(negedge clk);
            exp = model(h, l, n, t);
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL %s h=%0d l=%0d n=%0d cycle %0d: got %b expected %b",
                         name, h, l, n, t, obs(), exp);
            end
            if (noise && t < ncyc) begin
                start       = 1'($urandom_range(0, 1));
                high_cycles = 8'($urandom);
                low_cycles  = 8'($urandom);
                num_pulses  = 8'($urandom);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic check_idle(input string name, input int ncyc);
        for (int t = 1; t <= ncyc; t++) begin
            @(negedge clk);
            vectors++;
            if (obs() !== 5'b0) begin
                miscompares++;
                $display("FAIL %s idle cycle %0d: got %b expected 00000", name, t, obs());
            end
        end
    endtask

    task automatic do_abort(input string name, input int h, input int l, input int n, input int ta);
        logic [4:0] at_abort;
        logic [4:0] exp;
        start_train(h, l, n);
        check_train(name, h, l, n, ta, 1'b0);
        at_abort = model(h, l, n, ta);
        exp      = {3'b000, 2'b00};
        exp[2]   = at_abort[4];
        abort    = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL %s abort after cycle %0d: got %b expected %b", name, ta, obs(), exp);
        end
        check_idle({name, "_after"}, 3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        high_cycles = 8'd0;
        low_cycles  = 8'd0;
        num_pulses  = 8'd0;
        #2;
        vectors++;
        if (obs() !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_state: got %b expected 00000", obs());
        end
        check_idle("in_reset", 2);
        rst_n = 1'b1;
        check_idle("post_reset", 3);
    endtask

    task automatic test_spec_trains();
        start_train(2, 3, 2);
        check_train("h2l3n2", 2, 3, 2, train_len(2, 3, 2), 1'b0);
        check_idle("h2l3n2_tail", 2);
        start_train(0, 0, 3);
        check_train("h0l0n3", 0, 0, 3, train_len(0, 0, 3), 1'b0);
        check_idle("h0l0n3_tail", 2);
    endtask

    task automatic test_random_trains();
        int h;
        int l;
        int n;
        for (int i = 0; i < 14; i++) begin
            h = $urandom_range(0, 6);
            l = $urandom_range(0, 6);
            n = $urandom_range(1, 4);
            start_train(h, l, n);
            check_train("rand_train", h, l, n, train_len(h, l, n), 1'b1);
            if ($urandom_range(0, 1) == 1) check_idle("rand_gap", $urandom_range(1, 3));
        end
        check_idle("rand_tail", 2);
    endtask

    task automatic test_back_to_back();
        start_train(4, 4, 1);
        check_train("busy_start_ignored", 4, 4, 1, train_len(4, 4, 1), 1'b1);
        start_train(1, 1, 1);
        check_train("b2b_second", 1, 1, 1, train_len(1, 1, 1), 1'b0);
        check_idle("b2b_tail", 2);
    endtask

    task automatic test_abort();
        int h;
        int l;
        int n;
        do_abort("abort_fixed", 5, 5, 3, 2);
        for (int i = 0; i < 8; i++) begin
            h = $urandom_range(0, 5);
            l = $urandom_range(0, 5);
            n = $urandom_range(1, 3);
            do_abort("abort_rand", h, l, n, $urandom_range(1, train_len(h, l, n) - 1));
        end
        start_train(2, 2, 2);
        abort = 1'b1;
        check_idle("abort_with_start", 4);
        abort = 1'b0;
        start = 1'b0;
        check_idle("abort_with_start_tail", 2);
    endtask

    task automatic test_zero_pulses();
        logic [4:0] last;
        logic [4:0] exp;
        if (CONT) begin
            start_train(1, 2, 0);
            check_train("cont_mode", 1, 2, 0, 63, 1'b0);
            last   = model(1, 2, 0, 63);
            exp    = 5'b0;
            exp[2] = last[4];
            abort  = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL cont_abort: got %b expected %b", obs(), exp);
            end
            check_idle("cont_after_abort", 3);
        end else begin
            start_train(3, 4, 0);
            check_train("zero_pulses", 3, 4, 0, train_len(3, 4, 0), 1'b0);
            check_idle("zero_pulses_tail", 3);
        end
    endtask

    task automatic test_reset_mid_train();
        start_train(3, 4, 2);
        check_train("pre_reset", 3, 4, 2, 5, 1'b0);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obs() !== 5'b0) begin
            miscompares++;
            $display("FAIL async_reset: got %b expected 00000", obs());
        end
        check_idle("held_reset", 3);
        rst_n = 1'b1;
        check_idle("reset_release", 1);
        start_train(1, 1, 1);
        check_train("after_reset", 1, 1, 1, train_len(1, 1, 1), 1'b0);
        check_idle("after_reset_tail", 2);
    endtask

    initial begin
        test_reset();
        test_spec_trains();
        test_random_trains();
        test_back_to_back();
        test_abort();
        test_zero_pulses();
        test_reset_mid_train();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
